// File: rtl/fround_pkg.sv
// fround_pkg: shared types and helpers for the pipelined FP round-to-integral unit
package fround_pkg;
    typedef enum logic [1:0] {RM_RNE, RM_FLOOR, RM_CEIL, RM_TRUNC} rm_e;
    // Width-independent part of the stage-1 payload; vector fields travel alongside.
    typedef struct packed {
        logic sign;
        logic sel;
        logic inexact;
    } s1_flags_t;
    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    // Canonical quiet NaN {0, all-ones exp, 1, 0..0}, truncated by the caller to W bits.
    function automatic logic [63:0] qnan(input int ew, input int mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction
endpackage

// File: rtl/fround_if.sv
// fround_if: valid/ready operand and result channels of the rounding unit
//   in_valid/in_ready/x/mode : operand channel, out_valid/out_ready/y/inexact : result channel
interface fround_if
    import fround_pkg::*;
#(
    parameter int W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    rm_e          mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         inexact;
    modport master (output in_valid, x, mode, out_ready, input in_ready, out_valid, y, inexact);
    modport slave  (input in_valid, x, mode, out_ready, output in_ready, out_valid, y, inexact);
endinterface

// File: rtl/fround_decode.sv
// fround_decode: combinational stage-1 classify, mask and increment selection
//   x/mode in; flags, exponent, masked significand, increment vector and special result out
module fround_decode
    import fround_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23,
    parameter int W  = 1 + EW + MW
) (
    input  logic [W-1:0]  x,
    input  rm_e           mode,
    output s1_flags_t     flags,
    output logic [EW-1:0] exp,
    output logic [MW:0]   sig,
    output logic [MW:0]   inc_vec,
    output logic [W-1:0]  spec_y
);
    localparam int BIAS = bias(EW);
    logic          sign, g, s, odd, tiny, big, all1, zero, half_up, one, inc;
    logic [EW-1:0] e;
    logic [MW-1:0] man, mask;
    logic [31:0]   d;
    logic [MW:0]   bit_d;
    always_comb begin
        sign    = x[W-1];
        e       = x[W-2:MW];
        man     = x[MW-1:0];
        // d = number of dropped fraction bits; only meaningful in the normal range
        d       = 32'(MW + BIAS) - 32'(e);
        bit_d   = (MW+1)'(1) << d;
        mask    = bit_d[MW-1:0] - MW'(1);
        g       = |(man & bit_d[MW:1]);
        s       = |(man & (mask >> 1));
        odd     = |({1'b1, man} & bit_d);
        all1    = &e;
        zero    = ~|x[W-2:0];
        big     = 32'(e) >= 32'(BIAS + MW);
        tiny    = ~zero & (32'(e) < 32'(BIAS));
        half_up = (32'(e) == 32'(BIAS - 1)) & |man;
        one     = mode == RM_RNE ? half_up : mode == RM_FLOOR ? sign : mode == RM_CEIL ? ~sign : 1'b0;
        inc     = mode == RM_RNE ? g & (s | odd) : mode == RM_FLOOR ? sign & (g | s) :
                  mode == RM_CEIL ? ~sign & (g | s) : 1'b0;
        flags.sign    = sign;
        flags.sel     = all1 | big | zero | tiny;
        flags.inexact = tiny | (~flags.sel & (g | s));
        exp     = e;
        sig     = {1'b1, man & ~mask};
        inc_vec = (~flags.sel & inc) ? bit_d : '0;
        spec_y  = (all1 & |man) ? W'(qnan(EW, MW)) :
                  tiny ? {sign, one ? EW'(BIAS) : EW'(0), MW'(0)} : x;
    end
endmodule

// File: rtl/fround_pipe.sv
// fround_pipe: 2-stage valid/ready pipeline rounding FP values to integral values
//   clk, rst (sync, active-high); io: fround_if slave carrying operand and result channels
module fround_pipe
    import fround_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input logic     clk,
    input logic     rst,
    fround_if.slave io
);
    localparam int W = 1 + EW + MW;
    s1_flags_t     dec_flags, s1_flags_q, s1_flags_d;
    logic [EW-1:0] dec_exp, s1_exp_q, s1_exp_d;
    logic [MW:0]   dec_sig, dec_inc, s1_sig_q, s1_sig_d, s1_inc_q, s1_inc_d;
    logic [W-1:0]  dec_spec, s1_spec_q, s1_spec_d, y_q, y_d, norm_y;
    logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, inexact_q, inexact_d;
    logic          s1_load, s2_load, accept;
    logic [MW+1:0] m;
    fround_decode #(.EW(EW), .MW(MW)) u_dec (
        .x(io.x), .mode(io.mode), .flags(dec_flags), .exp(dec_exp),
        .sig(dec_sig), .inc_vec(dec_inc), .spec_y(dec_spec)
    );
    always_comb begin
        s2_load    = ~s2_valid_q | io.out_ready;
        s1_load    = ~s1_valid_q | s2_load;
        accept     = io.in_valid & s1_load;
        // carry out of the significand renormalises by one exponent step
        m          = {1'b0, s1_sig_q} + {1'b0, s1_inc_q};
        norm_y     = m[MW+1] ? {s1_flags_q.sign, s1_exp_q + EW'(1), m[MW:1]}
                             : {s1_flags_q.sign, s1_exp_q, m[MW-1:0]};
        s1_valid_d = s1_load ? io.in_valid : s1_valid_q;
        s1_flags_d = accept ? dec_flags : s1_flags_q;
        s1_exp_d   = accept ? dec_exp : s1_exp_q;
        s1_sig_d   = accept ? dec_sig : s1_sig_q;
        s1_inc_d   = accept ? dec_inc : s1_inc_q;
        s1_spec_d  = accept ? dec_spec : s1_spec_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        y_d        = (s2_load & s1_valid_q) ? (s1_flags_q.sel ? s1_spec_q : norm_y) : y_q;
        inexact_d  = (s2_load & s1_valid_q) ? s1_flags_q.inexact : inexact_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_flags_q <= '0;
            s1_exp_q   <= '0;
            s1_sig_q   <= '0;
            s1_inc_q   <= '0;
            s1_spec_q  <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            inexact_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_flags_q <= s1_flags_d;
            s1_exp_q   <= s1_exp_d;
            s1_sig_q   <= s1_sig_d;
            s1_inc_q   <= s1_inc_d;
            s1_spec_q  <= s1_spec_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            inexact_q  <= inexact_d;
        end
    end
    assign io.in_ready  = s1_load;
    assign io.out_valid = s2_valid_q;
    assign io.y         = y_q;
    assign io.inexact   = inexact_q;
endmodule

// File: tb/tb_fround_pipe.sv
// tb_fround_pipe: directed and streamed checks of fround_pipe against an arithmetic model
module tb_fround_pipe;
    import fround_pkg::*;
    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;
    bit   rnd = 0;
    logic [32:0] exp_q[$];
    logic        held = 0;
    logic [31:0] hy;
    logic        hi;
    fround_if #(.W(32)) io ();
    fround_pipe #(.EW(8), .MW(23)) dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;

    // Rounds by integer division of the exact value: n = floor(|x|), remainder vs half.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [1:0] md);
        logic        s, up;
        logic [7:0]  e;
        logic [63:0] sig, n, rem, half;
        int          sh, p;
        s = x[31];
        e = x[30:23];
        if (e == 8'hFF) return (x[22:0] != 0) ? {1'b0, 32'h7FC00000} : {1'b0, x};
        if (e >= 8'd150) return {1'b0, x};
        sig  = (e == 0) ? {41'd0, x[22:0]} : {40'd0, 1'b1, x[22:0]};
        sh   = 150 - ((e == 0) ? 1 : int'(e));
        if (sh > 60) sh = 60;
        n    = sig >> sh;
        rem  = sig - (n << sh);
        half = 64'd1 << (sh - 1);
        if (rem == 0) up = 0;
        else if (md == 2'd0) up = (rem > half) || (rem == half && n[0]);
        else if (md == 2'd1) up = s;
        else if (md == 2'd2) up = !s;
        else up = 0;
        n = n + 64'(up);
        if (n == 0) return {rem != 0, s, 31'd0};
        p = 0;
        for (int i = 0; i < 64; i++) if (n[i]) p = i;
        return {rem != 0, s, 8'(127 + p), 23'(n << (23 - p))};
    endfunction

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] xv, input logic [1:0] md);
        bit ok = 0;
        io.in_valid = 1;
        io.x        = xv;
        io.mode     = rm_e'(md);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = io.in_ready;
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout x=%h in_ready=%b want=1", xv, io.in_ready);
        end
        @(posedge clk);
        #1;
        io.in_valid = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (held) begin
                checks++;
                if (!io.out_valid || io.y !== hy || io.inexact !== hi) begin
                    errors++;
                    $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b", io.out_valid, io.y, io.inexact, hy, hi);
                end
            end
            if (io.in_valid && io.in_ready) exp_q.push_back(model(io.x, io.mode));
            if (io.out_valid && io.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got=%h want=none", io.y);
                end else begin
                    logic [32:0] ex;
                    ex = exp_q.pop_front();
                    if ({io.inexact, io.y} !== ex) begin
                        errors++;
                        $display("FAIL result got=%b/%h want=%b/%h", io.inexact, io.y, ex[32], ex[31:0]);
                    end
                end
            end
            held = io.out_valid && !io.out_ready;
            hy   = io.y;
            hi   = io.inexact;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) io.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {logic [31:0] x; logic [1:0] md; logic [31:0] y; logic ix;} vec_t;
    vec_t vecs[$] = '{
        '{32'hBFC00000, 2'd1, 32'hC0000000, 1'b1},
        '{32'hBFC00000, 2'd3, 32'hBF800000, 1'b1},
        '{32'h40200000, 2'd0, 32'h40000000, 1'b1},
        '{32'h40600000, 2'd0, 32'h40800000, 1'b1},
        '{32'h3F000000, 2'd0, 32'h00000000, 1'b1},
        '{32'h3E800000, 2'd2, 32'h3F800000, 1'b1},
        '{32'hBE800000, 2'd2, 32'h80000000, 1'b1},
        '{32'h80000001, 2'd1, 32'hBF800000, 1'b1},
        '{32'h7FC00001, 2'd0, 32'h7FC00000, 1'b0},
        '{32'hFF800000, 2'd0, 32'hFF800000, 1'b0},
        '{32'h4B7FFFFF, 2'd2, 32'h4B7FFFFF, 1'b0},
        '{32'h3F400000, 2'd0, 32'h3F800000, 1'b1},
        '{32'h80000000, 2'd2, 32'h80000000, 1'b0},
        '{32'h4AFFFFFF, 2'd0, 32'h4B000000, 1'b1}
    };

    initial begin
        io.in_valid  = 0;
        io.x         = '0;
        io.mode      = RM_RNE;
        io.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset_out_valid", 33'(io.out_valid), 33'd0);
        chk("reset_y", {io.inexact, io.y}, 33'd0);
        chk("reset_in_ready", 33'(io.in_ready), 33'd1);
        foreach (vecs[i]) chk($sformatf("model_%0d", i), model(vecs[i].x, vecs[i].md), {vecs[i].ix, vecs[i].y});
        @(posedge clk);
        #1;
        send(vecs[0].x, vecs[0].md);
        chk("latency_1", 33'(io.out_valid), 33'd0);
        @(posedge clk);
        #1;
        chk("latency_2", {io.out_valid, io.y}, {1'b1, vecs[0].y});
        repeat (2) @(posedge clk);
        #1;
        rnd = 1;
        foreach (vecs[i]) send(vecs[i].x, vecs[i].md);
        repeat (40) send($urandom, 2'($urandom_range(0, 3)));
        rnd = 0;
        @(posedge clk);
        #1;
        io.out_ready = 1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 33'(exp_q.size()), 33'd0);
        io.out_ready = 0;
        send(32'h40200000, 2'd0);
        send(32'hBFC00000, 2'd1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_flush", {io.out_valid, io.y}, 33'd0);
        io.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", 33'(io.out_valid), 33'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
